inst_cache: RTL and testbench
=============================

// Module: inst_cache
// PURPOSE
// Direct-mapped, one-word-per-line instruction cache between instruction fetch and the memory controller.
// - Hit: returns the instruction one cycle after the lookup.
// - Miss: issues a single 32-bit instruction read to the memory controller, installs the returned word, then answers fetch.
// - Hides the multi-cycle byte-serial RAM latency from the fetch stage on the hit path.
// PARAMETERS
// INDEX_BITS  8   log2(number of lines); index = addr[INDEX_BITS+1:2]
// ADDR_WIDTH  32  address width; tag = addr[ADDR_WIDTH-1:INDEX_BITS+2]
// INST_WIDTH  32  instruction width
// PORTS
// clk                      in   1           clock
// rst                      in   1           synchronous reset, active-high
// rdy                      in   1           global enable; low = freeze all state, outputs hold
// clear                    in   1           pipeline flush (mispredict); aborts any outstanding miss
// IF_inst_read_valid       in   1           fetch requests the instruction at IF_inst_addr
// IF_inst_addr             in   ADDR_WIDTH  fetch PC, word aligned
// IF_inst_valid            out  1           one-cycle pulse: IF_inst is valid
// IF_inst                  out  INST_WIDTH  instruction for the accepted request
// MemCtrl_inst_read_valid  out  1           miss request to the memory controller
// MemCtrl_inst_addr        out  ADDR_WIDTH  miss address; stable while the request is outstanding
// MemCtrl_inst_valid       in   1           fill-data pulse from the memory controller
// MemCtrl_inst             in   INST_WIDTH  fill word, little-endian assembled
// BEHAVIOUR
// - Reset: one clock; reset is synchronous and active-high (clk / rst). On rst:
//   - all valid bits = 0; state = IDLE
//   - IF_inst_valid = 0, IF_inst = 0, MemCtrl_inst_addr = 0, MemCtrl_inst_read_valid = 0
//   - rst mid-miss discards the miss; no line is installed.
// - Tag and data arrays are not reset; only the valid bits are. clear never invalidates lines.
// - FSM states: IDLE, MISS, RESP.
//   - IDLE, IF_inst_read_valid=1:
//     - Hit (valid[idx] && tag match): IF_inst <= data[idx]; IF_inst_valid <= 1; go to RESP.
//     - Miss: MemCtrl_inst_addr <= IF_inst_addr; go to MISS.
//   - MISS: MemCtrl_inst_read_valid = (state==MISS) && !MemCtrl_inst_valid. This is combinational.
//     - The request drops in the same cycle the fill pulse is seen, so the memory controller does not restart a fetch.
//     - On MemCtrl_inst_valid: write valid/tag/data[idx]; IF_inst <= MemCtrl_inst; IF_inst_valid <= 1; go to RESP.
//   - RESP: IF_inst_valid <= 0; go to IDLE.
//     - IF_inst_read_valid is ignored in this cycle, so the same request is never answered twice.
//     - Hit throughput: one instruction per 2 cycles.
// - Latency:
//   - Hit: IF_inst_valid is high in the cycle after the request is sampled.
//   - Miss: IF_inst_valid is high in the cycle after MemCtrl_inst_valid.
// - Fetch contract: IF_inst_addr is held stable while IF_inst_read_valid=1 until IF_inst_valid is seen.
// - clear (priority over everything except rst):
//   - state <= IDLE; IF_inst_valid <= 0; MemCtrl_inst_read_valid = 0 combinationally in the same cycle.
//   - If MemCtrl_inst_valid coincides with clear, the fill word is still installed (the address is correct) but not forwarded to fetch.
//   - A request present in the clear cycle is not accepted.
// - rdy=0: no state, array or register update. MemCtrl_inst_read_valid keeps its combinational value.
// - Address width rules: index/tag slicing only, no arithmetic. addr[1:0] is ignored.
// STRUCTURE
// - Shared include cpu_define.v supplies AddressBus, InstBus, Valid/Invalid, and the new constants:
//   - ICacheIndexBus, ICacheTagBus
//   - state encodings ICIdle, ICMiss, ICResp
// - One sub-module: inst_cache_array.
//   - Contains valid/tag/data storage: combinational read port (idx -> valid, tag, data) and a synchronous write port (we, idx, tag, data).
//   - Contains the valid-bit reset.
//   - The FSM stays in inst_cache.
// TESTING
// - Cold miss: request 0x0000 after reset; fill 0x00000513 returned 6 cycles later.
//   -> read_valid high until the fill; IF_inst=0x00000513 pulsed one cycle after the fill.
//   -> Repeating 0x0000: hit, pulse the next cycle, no memory request.
// - Conflict: fill 0x0000 (0x11111111), then 0x0400 (0x22222222), same index 0.
//   -> 0x0400 misses and evicts; a re-request of 0x0000 misses again and returns 0x11111111.
// - Back-to-back: hits at 0x0004 and 0x0008 requested continuously.
//   -> valid pulses 2 cycles apart, each with the correct word, never duplicated.
// - clear mid-miss: clear 2 cycles into the 0x0010 miss.
//   -> read_valid=0 the same cycle; no IF_inst_valid. A later fill is ignored; a new request to 0x0020 proceeds normally.
// - clear coincident with the fill of 0x0030:
//   -> no IF_inst_valid; a later 0x0030 request hits with the fill word.
// - rdy low for 3 cycles during a miss, and rst asserted mid-miss.
//   -> rdy low: state and outputs frozen, then resume correctly.
//   -> rst mid-miss: all outputs 0; a later request to the same address misses (valid cleared).

Source files
------------

// File: rtl/inst_cache_pkg.sv
// Shared types and default geometry for the instruction cache.
// Geometry constants, bus typedefs and FSM state encoding.
package inst_cache_pkg;

    localparam int IC_INDEX_BITS = 8;
    localparam int IC_ADDR_WIDTH = 32;
    localparam int IC_INST_WIDTH = 32;
    localparam int IC_TAG_BITS   = IC_ADDR_WIDTH - IC_INDEX_BITS - 2;

    typedef logic [IC_ADDR_WIDTH-1:0] address_bus_t;
    typedef logic [IC_INST_WIDTH-1:0] inst_bus_t;
    typedef logic [IC_INDEX_BITS-1:0] icache_index_bus_t;
    typedef logic [IC_TAG_BITS-1:0]   icache_tag_bus_t;

    localparam logic VALID   = 1'b1;
    localparam logic INVALID = 1'b0;

    typedef enum logic [1:0] {
        IC_IDLE = 2'd0,
        IC_MISS = 2'd1,
        IC_RESP = 2'd2
    } ic_state_e;

endpackage

// File: rtl/inst_cache_array.sv
// Valid/tag/data storage for the direct-mapped instruction cache.
// Combinational read port, synchronous write port; only valid bits reset.
module inst_cache_array
    import inst_cache_pkg::*;
#(
    parameter int INDEX_BITS = IC_INDEX_BITS,
    parameter int TAG_BITS   = IC_TAG_BITS,
    parameter int DATA_WIDTH = IC_INST_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INDEX_BITS-1:0] rd_idx,
    output logic                  rd_valid,
    output logic [TAG_BITS-1:0]   rd_tag,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  we,
    input  logic [INDEX_BITS-1:0] wr_idx,
    input  logic [TAG_BITS-1:0]   wr_tag,
    input  logic [DATA_WIDTH-1:0] wr_data
);

    localparam int LINES = 1 << INDEX_BITS;

    logic [LINES-1:0]      valid_q;
    logic [TAG_BITS-1:0]   tag_q  [LINES];
    logic [DATA_WIDTH-1:0] data_q [LINES];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (we) begin
            valid_q[wr_idx] <= VALID;
        end
    end

    // Tag and data are meaningless until the valid bit is set, so no reset.
    always_ff @(posedge clk) begin
        if (we) begin
            tag_q[wr_idx]  <= wr_tag;
            data_q[wr_idx] <= wr_data;
        end
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_data  = data_q[rd_idx];

endmodule

// File: rtl/inst_cache.sv
// Direct-mapped, one-word-per-line instruction cache.
// Single-cycle hits; misses fetch one word from the memory controller.
module inst_cache
    import inst_cache_pkg::*;
#(
    parameter int INDEX_BITS = IC_INDEX_BITS,
    parameter int ADDR_WIDTH = IC_ADDR_WIDTH,
    parameter int INST_WIDTH = IC_INST_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  clear,
    input  logic                  IF_inst_read_valid,
    input  logic [ADDR_WIDTH-1:0] IF_inst_addr,
    output logic                  IF_inst_valid,
    output logic [INST_WIDTH-1:0] IF_inst,
    output logic                  MemCtrl_inst_read_valid,
    output logic [ADDR_WIDTH-1:0] MemCtrl_inst_addr,
    input  logic                  MemCtrl_inst_valid,
    input  logic [INST_WIDTH-1:0] MemCtrl_inst
);

    localparam int TAG_BITS = ADDR_WIDTH - INDEX_BITS - 2;

    ic_state_e state, state_n;

    logic                  inst_valid_n;
    logic [INST_WIDTH-1:0] inst_n;
    logic [ADDR_WIDTH-1:0] mem_addr_n;

    logic [INDEX_BITS-1:0] req_idx;
    logic [TAG_BITS-1:0]   req_tag;
    logic [INDEX_BITS-1:0] fill_idx;
    logic [TAG_BITS-1:0]   fill_tag;

    logic                  line_valid;
    logic [TAG_BITS-1:0]   line_tag;
    logic [INST_WIDTH-1:0] line_data;
    logic                  hit;
    logic                  fill_we;
    logic                  unused_ok;

    assign req_idx  = IF_inst_addr[INDEX_BITS+1:2];
    assign req_tag  = IF_inst_addr[ADDR_WIDTH-1:INDEX_BITS+2];
    assign fill_idx = MemCtrl_inst_addr[INDEX_BITS+1:2];
    assign fill_tag = MemCtrl_inst_addr[ADDR_WIDTH-1:INDEX_BITS+2];

    assign unused_ok = ^{IF_inst_addr[1:0], MemCtrl_inst_addr[1:0]};

    assign hit = line_valid && (line_tag == req_tag);

    // A fill coinciding with clear is still installed: the address is right.
    assign fill_we = rdy && (state == IC_MISS) && MemCtrl_inst_valid;

    assign MemCtrl_inst_read_valid = (state == IC_MISS)
                                  && !MemCtrl_inst_valid
                                  && !clear
                                  && !rst;

    inst_cache_array #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_BITS   (TAG_BITS),
        .DATA_WIDTH (INST_WIDTH)
    ) u_array (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (req_idx),
        .rd_valid (line_valid),
        .rd_tag   (line_tag),
        .rd_data  (line_data),
        .we       (fill_we),
        .wr_idx   (fill_idx),
        .wr_tag   (fill_tag),
        .wr_data  (MemCtrl_inst)
    );

    always_comb begin
        state_n      = state;
        inst_valid_n = IF_inst_valid;
        inst_n       = IF_inst;
        mem_addr_n   = MemCtrl_inst_addr;
        if (clear) begin
            state_n      = IC_IDLE;
            inst_valid_n = 1'b0;
        end else begin
            unique case (state)
                IC_IDLE: begin
                    inst_valid_n = 1'b0;
                    if (IF_inst_read_valid) begin
                        if (hit) begin
                            inst_n       = line_data;
                            inst_valid_n = 1'b1;
                            state_n      = IC_RESP;
                        end else begin
                            mem_addr_n = IF_inst_addr;
                            state_n    = IC_MISS;
                        end
                    end
                end
                IC_MISS: begin
                    if (MemCtrl_inst_valid) begin
                        inst_n       = MemCtrl_inst;
                        inst_valid_n = 1'b1;
                        state_n      = IC_RESP;
                    end
                end
                // The request is ignored here so one fetch is never answered twice.
                IC_RESP: begin
                    inst_valid_n = 1'b0;
                    state_n      = IC_IDLE;
                end
                default: begin
                    inst_valid_n = 1'b0;
                    state_n      = IC_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IC_IDLE;
            IF_inst_valid     <= 1'b0;
            IF_inst           <= '0;
            MemCtrl_inst_addr <= '0;
        end else if (rdy) begin
            state             <= state_n;
            IF_inst_valid     <= inst_valid_n;
            IF_inst           <= inst_n;
            MemCtrl_inst_addr <= mem_addr_n;
        end
    end

endmodule

// File: tb/tb_inst_cache.sv
// Randomised self-checking bench for inst_cache.
// Reference model: per-line resident word address and data, plus backing memory.
module tb_inst_cache;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        clear;
    logic        IF_inst_read_valid;
    logic [31:0] IF_inst_addr;
    logic        IF_inst_valid;
    logic [31:0] IF_inst;
    logic        MemCtrl_inst_read_valid;
    logic [31:0] MemCtrl_inst_addr;
    logic        MemCtrl_inst_valid;
    logic [31:0] MemCtrl_inst;

    int n_checks = 0;
    int n_errors = 0;

    bit          m_v  [256];
    logic [29:0] m_wa [256];
    logic [31:0] m_d  [256];
    logic [31:0] mem_ovr [logic [31:0]];

    inst_cache dut (
        .clk                     (clk),
        .rst                     (rst),
        .rdy                     (rdy),
        .clear                   (clear),
        .IF_inst_read_valid      (IF_inst_read_valid),
        .IF_inst_addr            (IF_inst_addr),
        .IF_inst_valid           (IF_inst_valid),
        .IF_inst                 (IF_inst),
        .MemCtrl_inst_read_valid (MemCtrl_inst_read_valid),
        .MemCtrl_inst_addr       (MemCtrl_inst_addr),
        .MemCtrl_inst_valid      (MemCtrl_inst_valid),
        .MemCtrl_inst            (MemCtrl_inst)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        if (mem_ovr.exists(w)) return mem_ovr[w];
        return {w[15:0], ~w[15:0]} ^ 32'h5A5A_1234;
    endfunction

    function automatic bit model_hit(input logic [31:0] a);
        return m_v[a[9:2]] && (m_wa[a[9:2]] == a[31:2]);
    endfunction

    task automatic model_fill(input logic [31:0] a, input logic [31:0] w);
        m_v[a[9:2]]  = 1'b1;
        m_wa[a[9:2]] = a[31:2];
        m_d[a[9:2]]  = w;
    endtask

    task automatic model_reset;
        for (int i = 0; i < 256; i++) m_v[i] = 1'b0;
    endtask

    // One complete fetch; hit or miss is decided by the model.
    task automatic fetch(input logic [31:0] a, input int lat);
        bit          hit;
        logic [31:0] w;
        hit = model_hit(a);
        IF_inst_read_valid = 1'b1;
        IF_inst_addr = a;
        #1;
        chk("idle_rv", MemCtrl_inst_read_valid, 0);
        tick;
        if (hit) begin
            chk("hit_v", IF_inst_valid, 1);
            chk("hit_d", IF_inst, m_d[a[9:2]]);
            chk("hit_rv", MemCtrl_inst_read_valid, 0);
        end else begin
            w = mem_word(a);
            chk("miss_addr", MemCtrl_inst_addr, a);
            chk("miss_rv", MemCtrl_inst_read_valid, 1);
            chk("miss_v", IF_inst_valid, 0);
            for (int k = 1; k < lat; k++) begin
                tick;
                chk("wait_rv", MemCtrl_inst_read_valid, 1);
                chk("wait_v", IF_inst_valid, 0);
            end
            MemCtrl_inst_valid = 1'b1;
            MemCtrl_inst = w;
            #1;
            chk("fill_rv", MemCtrl_inst_read_valid, 0);
            tick;
            MemCtrl_inst_valid = 1'b0;
            MemCtrl_inst = $urandom;
            chk("fill_v", IF_inst_valid, 1);
            chk("fill_d", IF_inst, w);
            model_fill(a, w);
        end
        IF_inst_read_valid = 1'b0;
        IF_inst_addr = $urandom;
        tick;
        chk("resp_v", IF_inst_valid, 0);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] w;
        rst = 1'b1;
        rdy = 1'b1;
        clear = 1'b0;
        IF_inst_read_valid = 1'b0;
        IF_inst_addr = '0;
        MemCtrl_inst_valid = 1'b0;
        MemCtrl_inst = '0;
        model_reset();
        tick;
        tick;
        chk("rst_v", IF_inst_valid, 0);
        chk("rst_d", IF_inst, 0);
        chk("rst_addr", MemCtrl_inst_addr, 0);
        chk("rst_rv", MemCtrl_inst_read_valid, 0);
        rst = 1'b0;
        tick;

        // Cold miss then hit
        mem_ovr[32'h0] = 32'h0000_0513;
        fetch(32'h0, 6);
        chk("cold_d", IF_inst, 32'h0000_0513);
        fetch(32'h0, 1);

        // Conflict on index 0
        mem_ovr[32'h0] = 32'h1111_1111;
        mem_ovr[32'h400] = 32'h2222_2222;
        fetch(32'h400, 3);
        chk("conf_evict", IF_inst, 32'h2222_2222);
        fetch(32'h0, 3);
        chk("conf_refill", IF_inst, 32'h1111_1111);

        // Back-to-back hits
        fetch(32'h4, 2);
        fetch(32'h8, 2);
        IF_inst_read_valid = 1'b1;
        IF_inst_addr = 32'h4;
        tick;
        chk("b2b_v0", IF_inst_valid, 1);
        chk("b2b_d0", IF_inst, mem_word(32'h4));
        IF_inst_addr = 32'h8;
        tick;
        chk("b2b_gap", IF_inst_valid, 0);
        tick;
        chk("b2b_v1", IF_inst_valid, 1);
        chk("b2b_d1", IF_inst, mem_word(32'h8));
        IF_inst_read_valid = 1'b0;
        tick;
        chk("b2b_end", IF_inst_valid, 0);

        // clear two cycles into a miss, then a stray late fill
        IF_inst_read_valid = 1'b1;
        IF_inst_addr = 32'h10;
        tick;
        chk("clr_rv0", MemCtrl_inst_read_valid, 1);
        tick;
        clear = 1'b1;
        IF_inst_read_valid = 1'b0;
        #1;
        chk("clr_rv", MemCtrl_inst_read_valid, 0);
        tick;
        clear = 1'b0;
        chk("clr_v", IF_inst_valid, 0);
        chk("clr_rv2", MemCtrl_inst_read_valid, 0);
        MemCtrl_inst_valid = 1'b1;
        MemCtrl_inst = 32'hDEAD_BEEF;
        tick;
        MemCtrl_inst_valid = 1'b0;
        chk("stray_v", IF_inst_valid, 0);
        tick;
        chk("stray_v2", IF_inst_valid, 0);
        fetch(32'h20, 3);
        fetch(32'h10, 2);

        // clear coincident with fill
        w = mem_word(32'h30);
        IF_inst_read_valid = 1'b1;
        IF_inst_addr = 32'h30;
        tick;
        tick;
        MemCtrl_inst_valid = 1'b1;
        MemCtrl_inst = w;
        clear = 1'b1;
        IF_inst_read_valid = 1'b0;
        #1;
        chk("cc_rv", MemCtrl_inst_read_valid, 0);
        tick;
        MemCtrl_inst_valid = 1'b0;
        clear = 1'b0;
        chk("cc_v", IF_inst_valid, 0);
        model_fill(32'h30, w);
        tick;
        chk("cc_v2", IF_inst_valid, 0);
        fetch(32'h30, 4);

        // Request in a clear cycle is not accepted
        IF_inst_read_valid = 1'b1;
        IF_inst_addr = 32'h30;
        clear = 1'b1;
        tick;
        clear = 1'b0;
        IF_inst_read_valid = 1'b0;
        chk("clrreq_v", IF_inst_valid, 0);
        tick;
        chk("clrreq_v2", IF_inst_valid, 0);

        // rdy low for three cycles during a miss
        w = mem_word(32'h40);
        IF_inst_read_valid = 1'b1;
        IF_inst_addr = 32'h40;
        tick;
        chk("rdy_rv0", MemCtrl_inst_read_valid, 1);
        rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick;
            chk("rdy_rv", MemCtrl_inst_read_valid, 1);
            chk("rdy_addr", MemCtrl_inst_addr, 32'h40);
            chk("rdy_v", IF_inst_valid, 0);
        end
        rdy = 1'b1;
        tick;
        chk("rdy_rv1", MemCtrl_inst_read_valid, 1);
        MemCtrl_inst_valid = 1'b1;
        MemCtrl_inst = w;
        tick;
        MemCtrl_inst_valid = 1'b0;
        chk("rdy_fv", IF_inst_valid, 1);
        chk("rdy_fd", IF_inst, w);
        model_fill(32'h40, w);
        IF_inst_read_valid = 1'b0;
        tick;
        chk("rdy_end", IF_inst_valid, 0);

        // Hit request held off while rdy is low
        IF_inst_read_valid = 1'b1;
        IF_inst_addr = 32'h40;
        rdy = 1'b0;
        tick;
        chk("rdyhit_hold", IF_inst_valid, 0);
        rdy = 1'b1;
        tick;
        chk("rdyhit_v", IF_inst_valid, 1);
        chk("rdyhit_d", IF_inst, w);
        IF_inst_read_valid = 1'b0;
        tick;
        chk("rdyhit_end", IF_inst_valid, 0);

        // rst mid-miss
        IF_inst_read_valid = 1'b1;
        IF_inst_addr = 32'h50;
        tick;
        tick;
        rst = 1'b1;
        IF_inst_read_valid = 1'b0;
        tick;
        rst = 1'b0;
        chk("rstm_v", IF_inst_valid, 0);
        chk("rstm_d", IF_inst, 0);
        chk("rstm_addr", MemCtrl_inst_addr, 0);
        chk("rstm_rv", MemCtrl_inst_read_valid, 0);
        model_reset();
        fetch(32'h50, 2);
        fetch(32'h0, 2);

        // Randomised traffic over colliding lines
        for (int n = 0; n < 200; n++) begin
            a = ($urandom_range(0, 3) << 10)
              | ($urandom_range(0, 7) << 2)
              | $urandom_range(0, 3);
            if ($urandom_range(0, 3) == 0) a[31] = 1'b1;
            fetch(a, $urandom_range(1, 8));
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
